// File: rtl/audio_stereo_in_if.sv
// Sample-stream bus between the stereo PDM front end and its consumer:
// show-ahead PCM head plus ack, and the FIFO status/overflow flags.
interface audio_stereo_in_if;
    logic [15:0] stereo_pcm;
    logic        stereo_pcm_rdy;
    logic        stereo_pcm_ack;
    logic        fifo_full;
    logic        overflow;
    logic        ovf_clr;

    modport master (
        output stereo_pcm,
        output stereo_pcm_rdy,
        output fifo_full,
        output overflow,
        input  stereo_pcm_ack,
        input  ovf_clr
    );

    modport slave (
        input  stereo_pcm,
        input  stereo_pcm_rdy,
        input  fifo_full,
        input  overflow,
        output stereo_pcm_ack,
        output ovf_clr
    );
endinterface

// File: rtl/audio_stereo_in.sv
// Stereo 1-bit PWM/PDM to 8-bit-per-channel PCM decimator with a show-ahead
// sample FIFO, sticky overflow flag and asynchronous active-high clear.
module audio_stereo_in #(
    parameter int WINDOW     = 255,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_audio,
    input  logic              aclr,
    input  logic              left_in,
    input  logic              right_in,
    audio_stereo_in_if.master pcm_bus
);

    localparam int         PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int         CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [7:0] LAST  = 8'(WINDOW - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic              left_s1, left_s2;
    logic              right_s1, right_s2;
    logic [7:0]        win_cnt;
    logic [7:0]        left_acc, right_acc;
    logic [7:0]        left_sum, right_sum;
    logic              window_end;

    logic [15:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_next;
    logic              rdy_q, full_q, overflow_q;
    logic              push, pop, write, drop;

    // Both channel inputs are asynchronous, so each gets a two-flop synchronizer.
    always_ff @(posedge clk_audio or posedge aclr) begin
        if (aclr) begin
            left_s1  <= 1'b0;
            left_s2  <= 1'b0;
            right_s1 <= 1'b0;
            right_s2 <= 1'b0;
        end else begin
            left_s1  <= left_in;
            left_s2  <= left_s1;
            right_s1 <= right_in;
            right_s2 <= right_s1;
        end
    end

    assign window_end = (win_cnt == LAST);
    assign left_sum   = left_acc + {7'd0, left_s2};
    assign right_sum  = right_acc + {7'd0, right_s2};

    // The last cycle's bit is folded into the pushed sample, so accumulators restart from zero.
    always_ff @(posedge clk_audio or posedge aclr) begin
        if (aclr) begin
            win_cnt   <= 8'd0;
            left_acc  <= 8'd0;
            right_acc <= 8'd0;
        end else if (window_end) begin
            win_cnt   <= 8'd0;
            left_acc  <= 8'd0;
            right_acc <= 8'd0;
        end else begin
            win_cnt   <= win_cnt + 8'd1;
            left_acc  <= left_sum;
            right_acc <= right_sum;
        end
    end

    assign push  = window_end;
    assign pop   = pcm_bus.stereo_pcm_ack && rdy_q;
    assign write = push && (!full_q || pop);
    assign drop  = push && full_q && !pop;

    always_comb begin
        count_next = count;
        case ({write, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_audio) begin
        if (write) begin
            mem[wr_ptr] <= {left_sum, right_sum};
        end
    end

    // Pointers wrap for free because the depth is a power of two.
    always_ff @(posedge clk_audio or posedge aclr) begin
        if (aclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_q  <= 1'b0;
            full_q <= 1'b0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count  <= count_next;
            rdy_q  <= (count_next != '0);
            full_q <= (count_next == DEPTH_C);
        end
    end

    // A drop on the same edge as a clear wins, so no lost sample goes unreported.
    always_ff @(posedge clk_audio or posedge aclr) begin
        if (aclr) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (pcm_bus.ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign pcm_bus.stereo_pcm     = rdy_q ? mem[rd_ptr] : 16'h0000;
    assign pcm_bus.stereo_pcm_rdy = rdy_q;
    assign pcm_bus.fifo_full      = full_q;
    assign pcm_bus.overflow       = overflow_q;

endmodule

// File: doc/audio_stereo_in.md
AUDIO_STEREO_IN -- requirements
Module: audio_stereo_in

Interface
REQ-001 Parameter WINDOW, default 255, SHALL set the decimation window length in clk_audio cycles; legal range is 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the number of 16-bit sample entries; it is a power of 2, minimum 2.
REQ-003 Port clk_audio, input, 1: the single clock; all logic SHALL be rising-edge clocked on it.
REQ-004 Port aclr, input, 1: asynchronous, active-high reset.
REQ-005 Port left_in, input, 1: left 1-bit PWM/PDM stream, asynchronous to clk_audio.
REQ-006 Port right_in, input, 1: right 1-bit PWM/PDM stream, asynchronous to clk_audio.
REQ-007 Port stereo_pcm_ack, input, 1: pops the head sample when stereo_pcm_rdy is high.
REQ-008 Port ovf_clr, input, 1: clears the overflow flag.
REQ-009 Port stereo_pcm, output, 16: head sample, {left[15:8], right[7:0]}, unsigned.
REQ-010 Port stereo_pcm_rdy, output, 1: the FIFO is non-empty and stereo_pcm is valid.
REQ-011 Port fifo_full, output, 1: the FIFO holds FIFO_DEPTH entries.
REQ-012 Port overflow, output, 1: sticky flag; at least one sample has been dropped.

Function
REQ-013 Each of left_in and right_in SHALL pass through a 2-flop synchronizer; the synchronizer flops reset to 0.
REQ-014 The window counter SHALL count 0..WINDOW-1, increment every cycle, and wrap from WINDOW-1 to 0.
REQ-015 Each channel accumulator (8-bit) SHALL add that channel's synchronized bit on every cycle of the window, counting cycles 0..WINDOW-1 inclusive.
REQ-016 On the edge where the window counter equals WINDOW-1, the block SHALL:
  - form the sample from the final sums, including that cycle's bit;
  - push {left_sum, right_sum} into the FIFO;
  - zero both accumulators for the next window.
REQ-017 The accumulator result SHALL lie in 0..WINDOW; no saturation or wrap is required, since WINDOW is at most 255.
REQ-018 stereo_pcm_rdy SHALL assert on the cycle after a push into an empty FIFO; push-to-visible latency is 1 cycle.
REQ-019 The FIFO SHALL be show-ahead: stereo_pcm presents the oldest entry whenever stereo_pcm_rdy is 1, and reads 16'h0000 when the FIFO is empty.
REQ-020 stereo_pcm_ack with stereo_pcm_rdy=1 SHALL remove the head entry at that edge; stereo_pcm_ack while empty SHALL be ignored.
REQ-021 A push while full with no pop SHALL drop the new sample, leave the FIFO contents unchanged, and set overflow.
REQ-022 A push and a pop on the same edge while full SHALL both take effect: occupancy stays FIFO_DEPTH, fifo_full stays 1, and overflow is unchanged.
REQ-023 A push and a pop on the same edge with 1 entry SHALL leave occupancy at 1, with the new sample at the head.
REQ-024 ovf_clr SHALL clear overflow at the next edge; if a drop occurs on the same edge, overflow SHALL remain 1.
REQ-025 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; entries SHALL be popped in strict push order.

Reset
REQ-026 While aclr=1, the block SHALL force the following values immediately, independent of clk_audio:
  - window counter, accumulators, synchronizers, and FIFO pointers/occupancy to 0;
  - stereo_pcm=16'h0000, stereo_pcm_rdy=0, fifo_full=0, overflow=0.
REQ-027 On aclr assertion mid-window, the partial window SHALL be discarded and not pushed.
REQ-028 After aclr deasserts, the first counting cycle SHALL be window count 0.

Verification
REQ-029 Steady inputs: left_in=1, right_in=0 constant from reset release, WINDOW=255, ack held high.
  - First sample SHALL be 16'hFD00, with 2 synchronizer zero cycles counted.
  - Every later sample SHALL be 16'hFF00.
  - stereo_pcm_rdy SHALL pulse 1 cycle after each window end.
REQ-030 Toggling input: left_in toggles every cycle, right_in=1.
  - Each sample SHALL have left byte 8'd127 or 8'd128.
  - Each sample SHALL have right byte 8'hFF, after the first window.
REQ-031 Overflow: ack held 0 for 5 windows.
  - After window 4, fifo_full SHALL be 1.
  - Window 5 SHALL be dropped and overflow SHALL become 1.
  - 4 acks SHALL then return windows 1..4 in order.
  - stereo_pcm_rdy SHALL be 0 after the 4th ack.
REQ-032 Full boundary: with the FIFO full, ack on the same edge as a window push.
  - Occupancy SHALL stay 4 and overflow SHALL stay 0.
  - The oldest entry SHALL be removed and the newest entry appended.
REQ-033 Overflow clear: ovf_clr pulse -> overflow=0 next cycle; ovf_clr coincident with a drop -> overflow stays 1.
REQ-034 Mid-operation reset: aclr pulse at window count 100 with 2 entries queued.
  - All outputs SHALL be 0 immediately.
  - After release, the first push SHALL occur WINDOW cycles later.
